// File: rtl/lamp_sqrt_issue_ctrl_if.sv
// Bus bundle between an initiator and lamp_sqrt_issue_ctrl: the request
// channel, the sqrt-unit start/operand/result lines and the response channel.
// slave = controller side, master = the environment that drives it.
interface lamp_sqrt_issue_ctrl_if #(
   parameter int LAMP_FLOAT_E_DW = 8,
   parameter int LAMP_FLOAT_F_DW = 7
);
   localparam int DW = 1 + LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW;

   logic                       req_valid_i;
   logic                       req_ready_o;
   logic [DW-1:0]              op_i;
   logic                       doSqrt_o;
   logic                       signum_op_o;
   logic [LAMP_FLOAT_E_DW-1:0] extExp_op_o;
   logic [LAMP_FLOAT_F_DW:0]   extMant_op_o;
   logic                       isInf_op_o;
   logic                       isZero_op_o;
   logic                       isSNAN_op_o;
   logic                       isQNAN_op_o;
   logic                       s_res_i;
   logic [LAMP_FLOAT_E_DW-1:0] e_res_i;
   logic [LAMP_FLOAT_F_DW-1:0] f_res_i;
   logic                       valid_i;
   logic                       res_valid_o;
   logic                       res_ready_i;
   logic [DW-1:0]              res_o;
   logic                       invalid_o;
   logic                       timeout_o;

   modport slave (
      input  req_valid_i, op_i, s_res_i, e_res_i, f_res_i, valid_i, res_ready_i,
      output req_ready_o, doSqrt_o, signum_op_o, extExp_op_o, extMant_op_o,
             isInf_op_o, isZero_op_o, isSNAN_op_o, isQNAN_op_o,
             res_valid_o, res_o, invalid_o, timeout_o
   );

   modport master (
      output req_valid_i, op_i, s_res_i, e_res_i, f_res_i, valid_i, res_ready_i,
      input  req_ready_o, doSqrt_o, signum_op_o, extExp_op_o, extMant_op_o,
             isInf_op_o, isZero_op_o, isSNAN_op_o, isQNAN_op_o,
             res_valid_o, res_o, invalid_o, timeout_o
   );
endinterface

// File: rtl/lamp_sqrt_issue_ctrl.sv
// Initiator-side front end for the LAMP FPU sqrt unit. Classifies a packed
// operand, answers zero/inf/NaN/negative operands locally, otherwise pulses
// doSqrt and waits (bounded by TIMEOUT_CYCLES) for the unit's result.
// Optional statistics counters: define LAMP_SQRT_ISSUE_STATS_EN.
module lamp_sqrt_issue_ctrl #(
   parameter int LAMP_FLOAT_E_DW = 8,
   parameter int LAMP_FLOAT_F_DW = 7,
   parameter int TIMEOUT_CYCLES  = 32
)(
   input logic                   clk,
   input logic                   rst,
   lamp_sqrt_issue_ctrl_if.slave bus
`ifdef LAMP_SQRT_ISSUE_STATS_EN
   ,
   output logic [15:0]           ops_cnt_o,
   output logic [15:0]           spec_cnt_o,
   output logic [7:0]            tmo_cnt_o
`endif
);
   localparam int E  = LAMP_FLOAT_E_DW;
   localparam int F  = LAMP_FLOAT_F_DW;
   localparam int DW = 1 + E + F;
   localparam logic [DW-1:0] QNAN    = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};
   localparam logic [DW-1:0] PINF    = {1'b0, {E{1'b1}}, {F{1'b0}}};
   localparam logic [8:0]    TMO_LIM = 9'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] op_q, res_q;
   logic          inv_q, tmo_q;
   logic [7:0]    cnt_q;
   logic          req_ready, do_sqrt, res_valid, tmo_hit, accept;

   // incoming operand classification (decides special vs. issue at accept)
   logic          in_sign, in_zero, in_emax, in_nan, in_snan, in_special;
   logic [E-1:0]  in_exp;
   logic [F-1:0]  in_frac;
   logic [DW-1:0] spec_res;
   logic          spec_inv;

   assign in_sign    = bus.op_i[DW-1];
   assign in_exp     = bus.op_i[DW-2 -: E];
   assign in_frac    = bus.op_i[F-1:0];
   assign in_zero    = (in_exp == '0);
   assign in_emax    = &in_exp;
   assign in_nan     = in_emax & (|in_frac);
   assign in_snan    = in_nan & ~in_frac[F-1];
   assign in_special = in_zero | in_emax | in_sign;

   // locally resolved result; NaN is checked first so a negative NaN follows NaN rules
   always_comb begin
      spec_res = PINF;
      spec_inv = 1'b0;
      if (in_nan) begin
         spec_res = QNAN;
         spec_inv = in_snan;
      end else if (in_zero) begin
         spec_res = {in_sign, {(DW-1){1'b0}}};
      end else if (in_sign) begin
         spec_res = QNAN;
         spec_inv = 1'b1;
      end
   end

   // cnt_q counts completed WAIT cycles; this cycle is the last one allowed
   assign tmo_hit = ({1'b0, cnt_q} + 9'd1) >= TMO_LIM;
   assign accept  = req_ready & bus.req_valid_i;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next state and handshake strobes
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      do_sqrt   = 1'b0;
      res_valid = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid_i) state_d = in_special ? RESP : ISSUE;
         end
         ISSUE: begin
            do_sqrt = 1'b1;
            state_d = WAIT;
         end
         WAIT: if (bus.valid_i || tmo_hit) state_d = RESP;
         RESP: begin
            res_valid = 1'b1;
            if (bus.res_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // operand/result registers and wait counter; valid_i beats timeout in WAIT
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q  <= '0;
         res_q <= '0;
         inv_q <= 1'b0;
         tmo_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               op_q  <= bus.op_i;
               res_q <= spec_res;
               inv_q <= spec_inv;
               tmo_q <= 1'b0;
            end
            ISSUE: cnt_q <= '0;
            WAIT: begin
               cnt_q <= cnt_q + 8'd1;
               if (bus.valid_i) begin
                  res_q <= {bus.s_res_i, bus.e_res_i, bus.f_res_i};
                  inv_q <= 1'b0;
                  tmo_q <= 1'b0;
               end else if (tmo_hit) begin
                  res_q <= QNAN;
                  inv_q <= 1'b0;
                  tmo_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // operand fields are only presented while the unit is being driven
   logic          fld_en;
   logic [E-1:0]  q_exp;
   logic [F-1:0]  q_frac;
   assign fld_en = (state_q == ISSUE) || (state_q == WAIT);
   assign q_exp  = op_q[DW-2 -: E];
   assign q_frac = op_q[F-1:0];

   assign bus.req_ready_o  = req_ready;
   assign bus.doSqrt_o     = do_sqrt;
   assign bus.signum_op_o  = fld_en & op_q[DW-1];
   assign bus.extExp_op_o  = fld_en ? q_exp : '0;
   assign bus.extMant_op_o = fld_en ? {|q_exp, q_frac} : '0;
   assign bus.isInf_op_o   = fld_en & (&q_exp) & ~(|q_frac);
   assign bus.isZero_op_o  = fld_en & ~(|q_exp);
   assign bus.isQNAN_op_o  = fld_en & (&q_exp) & (|q_frac) & q_frac[F-1];
   assign bus.isSNAN_op_o  = fld_en & (&q_exp) & (|q_frac) & ~q_frac[F-1];
   assign bus.res_valid_o  = res_valid;
   assign bus.res_o        = res_q;
   assign bus.invalid_o    = inv_q;
   assign bus.timeout_o    = tmo_q;

`ifdef LAMP_SQRT_ISSUE_STATS_EN
   // saturating event counters
   always_ff @(posedge clk) begin
      if (rst) begin
         ops_cnt_o  <= '0;
         spec_cnt_o <= '0;
         tmo_cnt_o  <= '0;
      end else begin
         if (res_valid && bus.res_ready_i && ops_cnt_o != '1)
            ops_cnt_o <= ops_cnt_o + 16'd1;
         if (accept && in_special && spec_cnt_o != '1)
            spec_cnt_o <= spec_cnt_o + 16'd1;
         if (state_q == WAIT && !bus.valid_i && tmo_hit && tmo_cnt_o != '1)
            tmo_cnt_o <= tmo_cnt_o + 8'd1;
      end
   end
`endif
endmodule

// File: doc/lamp_sqrt_issue_ctrl.md
Name: lamp_sqrt_issue_ctrl

Overview:
- Front-end controller that drives the LAMP FPU square-root unit from the initiator side.
- Accepts a packed bfloat16-style operand (1/8/7) on a valid/ready request channel.
- Unpacks and classifies the operand, then either resolves special cases locally or issues a doSqrt pulse and waits for the unit's valid.
- Repacks the result and returns it on a valid/ready response channel.

Parameters:
- LAMP_FLOAT_E_DW, 8, exponent width
- LAMP_FLOAT_F_DW, 7, fraction width
- TIMEOUT_CYCLES, 32, maximum WAIT cycles before an abort; range 1..255

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  1  operand valid
- req_ready_o  out  1  controller can accept an operand
- op_i  in  16  packed operand {sign, exp[7:0], frac[6:0]}
- doSqrt_o  out  1  one-cycle start pulse to the sqrt unit
- signum_op_o  out  1  operand sign
- extExp_op_o  out  8  operand exponent
- extMant_op_o  out  8  {hidden bit, frac}
- isInf_op_o, isZero_op_o, isSNAN_op_o, isQNAN_op_o  out  1 each  operand class
- s_res_i  in  1  sqrt unit result sign
- e_res_i  in  8  sqrt unit result exponent
- f_res_i  in  7  sqrt unit result fraction
- valid_i  in  1  sqrt unit result valid (single-cycle pulse)
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result consumer ready
- res_o  out  16  packed result
- invalid_o  out  1  invalid-operation flag, qualified by res_valid_o
- timeout_o  out  1  sqrt unit did not answer, qualified by res_valid_o

Behaviour:
- Reset: clk and rst only, synchronous active-high. All outputs are 0 except req_ready_o=1. The FSM goes to IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, register op_i.
  - Special case: go to RESP next cycle with the result computed below.
  - Otherwise go to ISSUE.
- Unpack:
  - sign=op[15], exp=op[14:7], frac=op[6:0].
  - extMant = {exp!=0, frac}.
  - zero when exp==0; denormals are flushed to zero.
  - inf when exp==255 and frac==0.
  - QNAN when exp==255, frac!=0 and frac[6]=1.
  - SNAN when exp==255, frac!=0 and frac[6]=0.
- Specials (resolved locally, the sqrt unit is not started):
  - ±0 returns ±0 with the sign preserved (0x0000 or 0x8000).
  - +inf returns 0x7F80.
  - Any NaN returns 0x7FC0; invalid_o=1 for SNAN only.
  - Negative nonzero (including -inf) returns 0x7FC0 with invalid_o=1.
- ISSUE:
  - doSqrt_o=1 for exactly this cycle.
  - Operand fields are driven from the register; they stay stable from ISSUE until WAIT exits.
  - Next state is WAIT.
- WAIT:
  - An 8-bit counter is cleared in ISSUE and increments each WAIT cycle.
  - On valid_i, capture res={s_res_i, e_res_i, f_res_i} and go to RESP.
  - Else if the count reaches TIMEOUT_CYCLES, set res=0x7FC0 and timeout_o=1, then go to RESP.
  - If valid_i and the timeout coincide, valid_i wins.
- RESP:
  - res_valid_o=1; res_o, invalid_o and timeout_o are held stable.
  - On res_ready_i, go to IDLE.
  - Outputs hold unchanged while res_ready_i=0.
- req_ready_o=0 in ISSUE, WAIT and RESP. There is no same-cycle RESP→accept; the next accept is earliest one cycle after the RESP handshake.
- valid_i outside WAIT is ignored, for example a late pulse after a timeout or after a reset.
- Latency:
  - Special case: accept at cycle T, res_valid_o at T+1.
  - Normal case: doSqrt_o at T+1; res_valid_o the cycle after valid_i.
- A reset mid-operation aborts in any state and drops any pending result.

Optional Feature:
- Macro: LAMP_SQRT_ISSUE_STATS_EN.
- When defined, the block adds output ports:
  - ops_cnt_o  out 16  completed responses, counted at the RESP handshake
  - spec_cnt_o  out 16  specials resolved locally
  - tmo_cnt_o  out 8  timeouts
- All counters saturate (no wrap) and clear on rst.
- When undefined, these ports and the counters are absent; all other behaviour is identical.

Test Plan:
- 4.0: op_i=0x4080 → doSqrt_o pulse at T+1 with extExp=0x81, extMant=0x80, isZero=0. The model returns e=0x80, f=0x00 three cycles later → res_o=0x4000, invalid_o=0, timeout_o=0.
- Negative zero: op_i=0x8000 → no doSqrt_o; at T+1 res_o=0x8000, invalid_o=0. Positive infinity: op_i=0x7F80 → res_o=0x7F80.
- Negative and NaN operands: op_i=0xC080 → res_o=0x7FC0, invalid_o=1. op_i=0x7F81 (SNAN) → 0x7FC0, invalid_o=1. op_i=0x7FC1 (QNAN) → 0x7FC0, invalid_o=0.
- Timeout: TIMEOUT_CYCLES=4 with the model silent → res_valid_o in RESP with res_o=0x7FC0 and timeout_o=1. A subsequent stray valid_i in IDLE is ignored.
- Backpressure: hold res_ready_i=0 for 5 cycles → res_o and res_valid_o stable and req_ready_o=0; release → IDLE next cycle, req_ready_o=1.
- Reset mid-operation: assert rst in WAIT, then have the model assert valid_i → no res_valid_o, req_ready_o=1. With LAMP_SQRT_ISSUE_STATS_EN: after the above, counters match the expected counts, and all read 0 after rst.
